// File: rtl/multicycle_controller_pkg.sv
// Shared opcode constants, FSM state encoding and instruction field layout
// for the multicycle instruction controller.
package ctrl_pkg;

    localparam int DEF_REG_W = 6;
    localparam int DEF_OP_W  = 4;
    localparam int DEF_IMM_W = 9;

    localparam logic [3:0] OP_LOAD  = 4'b0100;
    localparam logic [3:0] OP_STORE = 4'b0110;
    localparam logic [3:0] OP_NOP   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MEM  = 2'd2,
        WB   = 2'd3
    } state_t;

    // Field view of an instruction at the default widths, MSB first.
    typedef struct packed {
        logic                 ri;
        logic [DEF_REG_W-1:0] rs;
        logic [DEF_REG_W-1:0] rd;
        logic [DEF_OP_W-1:0]  op;
        logic [DEF_REG_W-1:0] rt;
        logic [DEF_IMM_W-1:0] imm;
    } instr_fields_t;

    function automatic int instr_width(input int reg_w, input int op_w, input int imm_w);
        return 1 + 3 * reg_w + op_w + imm_w;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction-fetch and data-memory handshakes of the controller.
// master = controller side, slave = fetch unit / data memory side.
interface multicycle_controller_if #(
    parameter int REG_W = 6,
    parameter int OP_W  = 4,
    parameter int IMM_W = 9
);
    localparam int INSTR_W = 1 + 3 * REG_W + OP_W + IMM_W;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic               dm_req;
    logic               dm_we;
    logic               dm_ack;

    modport master (
        input  instr_valid,
        output instr_ready,
        input  instr,
        output dm_req,
        output dm_we,
        input  dm_ack
    );

    modport slave (
        output instr_valid,
        input  instr_ready,
        output instr,
        input  dm_req,
        input  dm_we,
        output dm_ack
    );

endinterface

// File: rtl/multicycle_controller_imm_extend.sv
// Widens the IMM field to the datapath width, sign- or zero-extending.
module imm_extend #(
    parameter int IMM_W    = 9,
    parameter int DATA_W   = 32,
    parameter int SIGN_EXT = 1
) (
    input  logic [IMM_W-1:0]  imm,
    output logic [DATA_W-1:0] imm_ext
);

    assign imm_ext[IMM_W-1:0] = imm;

    generate
        for (genvar gi = IMM_W; gi < DATA_W; gi++) begin : g_ext
            assign imm_ext[gi] = (SIGN_EXT != 0) ? imm[IMM_W-1] : 1'b0;
        end
    endgenerate

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle instruction controller: latches one instruction, sequences
// ALU / NOP / load / store through IDLE-EXEC-MEM-WB, counts retirements.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int REG_W        = 6,
    parameter int OP_W         = 4,
    parameter int IMM_W        = 9,
    parameter int DATA_W       = 32,
    parameter int SIGN_EXT_IMM = 1,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    multicycle_controller_if.master  bus,
    output logic                     ri,
    output logic [REG_W-1:0]         rs,
    output logic [REG_W-1:0]         rd,
    output logic [REG_W-1:0]         rt,
    output logic [OP_W-1:0]          alu_op,
    output logic [DATA_W-1:0]        imm_ext,
    output logic                     rf_we,
    output logic                     wb_sel,
    output logic                     err,
    output logic [CNT_W-1:0]         retired_cnt
);

    localparam int INSTR_W = 1 + 3 * REG_W + OP_W + IMM_W;
    localparam int RS_LSB  = INSTR_W - 1 - REG_W;
    localparam int RD_LSB  = RS_LSB - REG_W;
    localparam int OP_LSB  = RD_LSB - OP_W;
    localparam int RT_LSB  = OP_LSB - REG_W;

    localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = (MEM_TIMEOUT > 0) ? TO_W'(MEM_TIMEOUT - 1) : '0;

    localparam logic [OP_W-1:0] OPC_LOAD  = OP_W'(OP_LOAD);
    localparam logic [OP_W-1:0] OPC_STORE = OP_W'(OP_STORE);
    localparam logic [OP_W-1:0] OPC_NOP   = OP_W'(OP_NOP);

    state_t             state_reg, state_next;
    logic [INSTR_W-1:0] instr_reg;
    logic [TO_W-1:0]    to_cnt_reg, to_cnt_next;
    logic [CNT_W-1:0]   retired_reg;
    logic               err_reg, err_next;
    logic               retire;

    logic is_load, is_store, is_nop, is_mem, to_hit;

    // Decoded fields come straight from the instruction register so they
    // hold until the next accept.
    assign ri     = instr_reg[INSTR_W-1];
    assign rs     = instr_reg[RS_LSB +: REG_W];
    assign rd     = instr_reg[RD_LSB +: REG_W];
    assign alu_op = instr_reg[OP_LSB +: OP_W];
    assign rt     = instr_reg[RT_LSB +: REG_W];

    imm_extend #(
        .IMM_W    (IMM_W),
        .DATA_W   (DATA_W),
        .SIGN_EXT (SIGN_EXT_IMM)
    ) u_imm_extend (
        .imm     (instr_reg[IMM_W-1:0]),
        .imm_ext (imm_ext)
    );

    assign is_load  = (alu_op == OPC_LOAD);
    assign is_store = (alu_op == OPC_STORE);
    assign is_nop   = (alu_op == OPC_NOP);
    assign is_mem   = is_load || is_store;
    assign to_hit   = (MEM_TIMEOUT != 0) && (to_cnt_reg == TO_LAST);

    always_comb begin
        state_next  = state_reg;
        to_cnt_next = to_cnt_reg;
        err_next    = 1'b0;
        retire      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.instr_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (is_mem) begin
                    state_next  = MEM;
                    to_cnt_next = '0;
                end else begin
                    state_next = IDLE;
                    retire     = 1'b1;
                end
            end
            MEM: begin
                // An ack arriving on the threshold cycle takes priority.
                if (bus.dm_ack) begin
                    if (is_load) begin
                        state_next = WB;
                    end else begin
                        state_next = IDLE;
                        retire     = 1'b1;
                    end
                end else if (to_hit) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end
            WB: begin
                state_next = IDLE;
                retire     = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            instr_reg   <= '0;
            to_cnt_reg  <= '0;
            retired_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            to_cnt_reg <= to_cnt_next;
            err_reg    <= err_next;
            if (retire) begin
                retired_reg <= retired_reg + 1'b1;
            end
            if (state_reg == IDLE && bus.instr_valid) begin
                instr_reg <= bus.instr;
            end
        end
    end

    // Control strobes are forced low while reset is held, whatever the state.
    assign bus.instr_ready = !rst && (state_reg == IDLE);
    assign bus.dm_req      = !rst && (state_reg == MEM);
    assign bus.dm_we       = !rst && (state_reg == MEM) && is_store;
    assign rf_we           = !rst && (((state_reg == EXEC) && !is_mem && !is_nop)
                                      || (state_reg == WB));
    assign wb_sel          = (state_reg != WB);
    assign err             = !rst && err_reg;
    assign retired_cnt     = retired_reg;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Parametrised successor to the single-cycle instruction controller. Accepts one instruction over a valid/ready handshake and latches it. Decodes the fixed RI/RS/RD/OP/RT/IMM field layout and sequences ALU, load, store and NOP execution through a Moore FSM. Drives register-file and data-memory control, with a req/ack data-memory handshake, a memory timeout and a retired-instruction counter. Sits between instruction fetch and the ALU / register file / data memory datapath.

Parameters:
REG_W, 6, width of the RS/RD/RT register address fields
OP_W, 4, width of the OP (ALU function) field
IMM_W, 9, width of the IMM field
DATA_W, 32, width of the extended-immediate output
SIGN_EXT_IMM, 1, 1 = sign-extend IMM to DATA_W; 0 = zero-extend
MEM_TIMEOUT, 16, maximum MEM cycles without dm_ack; 0 disables the timeout
CNT_W, 16, width of the retired-instruction counter
INSTR_W (localparam), 1+3*REG_W+OP_W+IMM_W, instruction width; 32 at defaults

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  controller can accept an instruction
instr  in  INSTR_W  {RI, RS, RD, OP, RT, IMM}, MSB first
ri  out  1  latched RI bit; ALU operand-B select (1 = immediate path)
rs, rd, rt  out  REG_W each  latched register fields
alu_op  out  OP_W  latched OP field
imm_ext  out  DATA_W  latched IMM, extended per SIGN_EXT_IMM
rf_we  out  1  register-file write enable
wb_sel  out  1  0 = write back data-memory read data; 1 = ALU result
dm_req  out  1  data-memory request
dm_we  out  1  data-memory write (valid only while dm_req = 1)
dm_ack  in  1  data-memory completion
err  out  1  one-cycle pulse on memory timeout
retired_cnt  out  CNT_W  count of completed instructions

Behaviour:
- Opcodes are shared constants: OP_LOAD = 4'b0100, OP_STORE = 4'b0110, OP_NOP = 4'b1111. Every other OP value is an ALU op.
- FSM states are IDLE, EXEC, MEM and WB. All outputs are Moore outputs, decoded from the state and the latched instruction register.
- Reset: state = IDLE. The instruction register, retired_cnt and the timeout counter clear to 0. During reset rf_we = dm_req = dm_we = err = 0 and instr_ready = 0. Reset overrides every other event, including reset during MEM.
- IDLE: instr_ready = 1. If instr_valid is high at the edge, latch instr and go to EXEC. Otherwise stay in IDLE.
- EXEC (1 cycle), by latched OP:
  - ALU op: rf_we = 1, wb_sel = 1. Then IDLE; retired_cnt += 1.
  - OP_NOP: rf_we = 0. Then IDLE; retired_cnt += 1.
  - OP_LOAD or OP_STORE: go to MEM and clear the timeout counter.
- MEM: dm_req = 1, and dm_we = 1 for a store, 0 for a load. Hold until a cycle with dm_ack = 1.
  - Load ack: go to WB.
  - Store ack: go to IDLE; retired_cnt += 1.
  - No ack: timeout counter += 1.
- Timeout: when the timeout counter reaches MEM_TIMEOUT - 1 with no ack, err = 1 at the next edge for exactly one cycle. The FSM goes to IDLE, rf_we stays 0 and retired_cnt does not change.
- Ack on the same cycle as the timeout threshold: the ack wins and no err is raised.
- WB (1 cycle): rf_we = 1, wb_sel = 0. Then IDLE; retired_cnt += 1.
- dm_ack outside MEM is ignored.
- ALU and NOP instructions take 2 cycles from accept to ready. Loads take 3 + memory latency; stores take 2 + memory latency.
- wb_sel = 0 only in WB. In every other state wb_sel = 1.
- Decoded field outputs hold their values until the next accept.
- retired_cnt wraps modulo 2^CNT_W without saturating.

Decomposition:
- Package ctrl_pkg holds the OP_* constants, the state enum and a field-extraction struct parametrised by the default widths.
- Sub-module imm_extend handles the IMM_W to DATA_W extension, selected by SIGN_EXT_IMM.
- All other logic stays in one module.

Test Plan:
- ALU instr 32'h0209_0000 (RI=0, RS=1, RD=1, OP=0010): rf_we = 1 in the cycle after accept, wb_sel = 1, instr_ready low for 1 cycle, retired_cnt 0→1.
- NOP (OP=1111): no rf_we, no dm_req; back in IDLE after 2 cycles; retired_cnt increments.
- Load with RI=1, IMM=9'h1FF, SIGN_EXT_IMM=1: imm_ext = 32'hFFFF_FFFF. dm_req/dm_we = 1/0 for 3 cycles, ack on the 3rd, then one WB cycle with rf_we = 1 and wb_sel = 0.
- Store with dm_ack in the first MEM cycle: dm_req = dm_we = 1 for exactly 1 cycle, rf_we never asserted, retired_cnt += 1.
- Load with dm_ack never asserted, MEM_TIMEOUT = 4: dm_req high for 4 cycles, then a one-cycle err pulse, FSM back to IDLE, retired_cnt unchanged. Repeat with ack on the 4th MEM cycle: no err.
- rst asserted mid-MEM: dm_req = 0 in the following cycle, instr_ready = 1 after rst deasserts, and retired_cnt = 0. Separately, with CNT_W = 2, five ALU instructions give retired_cnt = 1 (wrap).
